// File: rtl/riscv_pkg.sv
// Shared definitions for the unified memory port arbiter: state encodings
// and the default response timeout.
package riscv_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_WAIT = 2'd1;
  localparam logic [1:0] ST_DM_WAIT = 2'd2;
  localparam logic [1:0] ST_IF_DROP = 2'd3;

  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_IF_WAIT = ST_IF_WAIT,
    S_DM_WAIT = ST_DM_WAIT,
    S_IF_DROP = ST_IF_DROP
  } arb_state_t;

endpackage

// File: rtl/fetch_mem_arbiter_wait_timer.sv
// Response wait counter: synchronous clear, count enable, and a terminal
// flag raised while the count sits at TIMEOUT-1 (the last allowed wait cycle).
module wait_timer #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic CLK,
  input  logic Clr,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] count;

  // Count wait cycles; clear has priority so every state entry starts at zero.
  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbiter/sequencer for the unified memory port shared by instruction fetch
// and the MEM stage. One outstanding transaction; data beats fetch; fetch
// responses overtaken by a redirect are dropped; hung transactions time out.
module fetch_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = 7
) (
  input  logic        CLK,
  input  logic        Clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        PCSrcE,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        StallF,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  arb_state_t state, state_next;
  logic       timer_tc;
  logic       timer_en;
  logic       timer_clr;

  // The timer runs only while a transaction is outstanding and restarts on
  // every state change, including the IF_WAIT -> IF_DROP hop.
  assign timer_en  = (state != S_IDLE);
  assign timer_clr = (state_next != state);

  wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_wait_timer (
    .CLK   (CLK),
    .Clr   (Clr),
    .clear (timer_clr),
    .enable(timer_en),
    .tc    (timer_tc)
  );

  // State register; reset may land mid-transaction and simply abandons it.
  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant, request mux, response routing and timeout abort.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    if_valid   = 1'b0;
    if_instr   = '0;
    dm_done    = 1'b0;
    dm_rdata   = '0;
    bus_err    = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Data first: the older instruction must finish to avoid deadlock.
        // A stray mem_rvalid here is a protocol error and is ignored.
        if (dm_req) begin
          mem_req   = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          mem_wstrb = dm_wstrb;
          if (mem_gnt) state_next = S_DM_WAIT;
        end else if (if_req && !PCSrcE) begin
          mem_req  = 1'b1;
          mem_addr = if_addr;
          if (mem_gnt) state_next = S_IF_WAIT;
        end
      end
      S_IF_WAIT: begin
        if (mem_rvalid) begin
          if (!PCSrcE) begin
            if_valid = 1'b1;
            if_instr = mem_rdata;
          end
          state_next = S_IDLE;
        end else if (timer_tc) begin
          bus_err    = 1'b1;
          state_next = S_IDLE;
        end else if (PCSrcE) begin
          state_next = S_IF_DROP;
        end
      end
      S_DM_WAIT: begin
        if (mem_rvalid) begin
          dm_done    = 1'b1;
          dm_rdata   = mem_rdata;
          state_next = S_IDLE;
        end else if (timer_tc) begin
          bus_err    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_IF_DROP: begin
        if (mem_rvalid) begin
          state_next = S_IDLE;
        end else if (timer_tc) begin
          bus_err    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign StallF = if_req & ~if_valid;
  assign StallM = dm_req & ~dm_done;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_fetch_mem_arbiter;

  logic        CLK;
  logic        Clr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        PCSrcE;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        StallF;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int n_checks;
  int n_errors;

  fetch_mem_arbiter #(
    .TIMEOUT(8),
    .CW     (4)
  ) dut (
    .CLK       (CLK),
    .Clr       (Clr),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .PCSrcE    (PCSrcE),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .StallF    (StallF),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_wstrb  (dm_wstrb),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .StallM    (StallM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    Clr        = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    PCSrcE     = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_wstrb   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state
    sample();
    chk_val("rst_mem_req",  32'(mem_req),  32'd0);
    chk_val("rst_if_valid", 32'(if_valid), 32'd0);
    chk_val("rst_dm_done",  32'(dm_done),  32'd0);
    chk_val("rst_bus_err",  32'(bus_err),  32'd0);
    chk_val("rst_stallf",   32'(StallF),   32'd0);
    chk_val("rst_stallm",   32'(StallM),   32'd0);
    next_cycle();
    Clr = 1'b1;
    sample();
    next_cycle();

    // Back-to-back fetches: one instruction every second cycle
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'h1000 + 32'(4 * i);
      mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
      sample();
      chk_val("f_req",    32'(mem_req),  32'd1);
      chk_val("f_addr",   mem_addr,      32'h1000 + 32'(4 * i));
      chk_val("f_we",     32'(mem_we),   32'd0);
      chk_val("f_wstrb",  32'(mem_wstrb), 32'd0);
      chk_val("f_stallf_req", 32'(StallF), 32'd1);
      chk_val("f_noval",  32'(if_valid), 32'd0);
      next_cycle();
      mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
      sample();
      chk_val("f_valid",  32'(if_valid), 32'd1);
      chk_val("f_instr",  if_instr,      32'h00500093);
      chk_val("f_stallf_ret", 32'(StallF), 32'd0);
      chk_val("f_wait_noreq", 32'(mem_req), 32'd0);
      next_cycle();
    end
    if_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;

    // Store and fetch together: store wins, fetch follows after its ack
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h2000; mem_gnt = 1'b1;
    sample();
    chk_val("st_req",   32'(mem_req),   32'd1);
    chk_val("st_we",    32'(mem_we),    32'd1);
    chk_val("st_addr",  mem_addr,       32'h100);
    chk_val("st_wdata", mem_wdata,      32'hDEADBEEF);
    chk_val("st_wstrb", 32'(mem_wstrb), 32'hF);
    chk_val("st_stallm", 32'(StallM),   32'd1);
    chk_val("st_stallf", 32'(StallF),   32'd1);
    next_cycle();
    mem_gnt = 1'b0;
    sample();
    chk_val("st_wait_req",  32'(mem_req), 32'd0);
    chk_val("st_wait_done", 32'(dm_done), 32'd0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    sample();
    chk_val("st_done",    32'(dm_done), 32'd1);
    chk_val("st_stallm0", 32'(StallM),  32'd0);
    chk_val("st_no_ifv",  32'(if_valid), 32'd0);
    next_cycle();
    dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1;
    sample();
    chk_val("st_f_req",  32'(mem_req), 32'd1);
    chk_val("st_f_addr", mem_addr,     32'h2000);
    chk_val("st_f_we",   32'(mem_we),  32'd0);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    sample();
    chk_val("st_f_valid", 32'(if_valid), 32'd1);
    chk_val("st_f_instr", if_instr,      32'h11111111);
    next_cycle();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // Redirect while waiting: response lands in IF_DROP and is discarded
    if_req = 1'b1; if_addr = 32'h3000; mem_gnt = 1'b1;
    sample();
    chk_val("dr_req", 32'(mem_req), 32'd1);
    next_cycle();
    mem_gnt = 1'b0; PCSrcE = 1'b1; if_addr = 32'h4000;
    sample();
    chk_val("dr_w1_ifv", 32'(if_valid), 32'd0);
    next_cycle();
    PCSrcE = 1'b0;
    sample();
    chk_val("dr_w2_noreq", 32'(mem_req), 32'd0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    sample();
    chk_val("dr_w3_ifv",    32'(if_valid), 32'd0);
    chk_val("dr_w3_noreq",  32'(mem_req),  32'd0);
    chk_val("dr_w3_stallf", 32'(StallF),   32'd1);
    next_cycle();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    sample();
    chk_val("dr_idle_req",  32'(mem_req), 32'd1);
    chk_val("dr_idle_addr", mem_addr,     32'h4000);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    sample();
    chk_val("dr_new_ifv",   32'(if_valid), 32'd1);
    chk_val("dr_new_instr", if_instr,      32'h22222222);
    next_cycle();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // Redirect and response in the same cycle
    if_req = 1'b1; if_addr = 32'h5000; mem_gnt = 1'b1;
    sample();
    chk_val("sc_req", 32'(mem_req), 32'd1);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    PCSrcE = 1'b1; if_addr = 32'h6000;
    sample();
    chk_val("sc_ifv",   32'(if_valid), 32'd0);
    chk_val("sc_noreq", 32'(mem_req),  32'd0);
    next_cycle();
    PCSrcE = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1;
    sample();
    chk_val("sc_new_req",  32'(mem_req), 32'd1);
    chk_val("sc_new_addr", mem_addr,     32'h6000);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33333333;
    sample();
    chk_val("sc_new_ifv", 32'(if_valid), 32'd1);
    chk_val("sc_new_instr", if_instr,    32'h33333333);
    next_cycle();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // Timeout: no response, bus_err exactly 8 cycles after the grant
    if_req = 1'b1; if_addr = 32'h7000; mem_gnt = 1'b1;
    sample();
    chk_val("to_req", 32'(mem_req), 32'd1);
    next_cycle();
    mem_gnt = 1'b0;
    for (int k = 1; k < 8; k++) begin
      sample();
      chk_val("to_quiet_err", 32'(bus_err), 32'd0);
      chk_val("to_quiet_req", 32'(mem_req), 32'd0);
      next_cycle();
    end
    sample();
    chk_val("to_err",    32'(bus_err),  32'd1);
    chk_val("to_ifv",    32'(if_valid), 32'd0);
    chk_val("to_stallf", 32'(StallF),   32'd1);
    next_cycle();
    mem_gnt = 1'b1;
    sample();
    chk_val("to_err_end", 32'(bus_err), 32'd0);
    chk_val("to_rereq",   32'(mem_req), 32'd1);
    chk_val("to_readdr",  mem_addr,     32'h7000);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h44444444;
    sample();
    chk_val("to_re_ifv", 32'(if_valid), 32'd1);
    next_cycle();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // Reset during DM_WAIT, stale response afterwards, then a clean load
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wstrb = 4'hF; mem_gnt = 1'b1;
    sample();
    chk_val("rs_req", 32'(mem_req), 32'd1);
    next_cycle();
    mem_gnt = 1'b0;
    sample();
    chk_val("rs_wait_noreq", 32'(mem_req), 32'd0);
    next_cycle();
    Clr = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    sample();
    chk_val("rs_in_req",  32'(mem_req), 32'd0);
    chk_val("rs_in_done", 32'(dm_done), 32'd0);
    chk_val("rs_in_err",  32'(bus_err), 32'd0);
    next_cycle();
    Clr = 1'b1;
    sample();
    chk_val("rs_stale_done", 32'(dm_done),  32'd0);
    chk_val("rs_stale_ifv",  32'(if_valid), 32'd0);
    chk_val("rs_stale_req",  32'(mem_req),  32'd0);
    next_cycle();
    mem_rvalid = 1'b0; dm_req = 1'b1; dm_addr = 32'h204; mem_gnt = 1'b1;
    sample();
    chk_val("rs_new_req",  32'(mem_req), 32'd1);
    chk_val("rs_new_addr", mem_addr,     32'h204);
    chk_val("rs_new_we",   32'(mem_we),  32'd0);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    sample();
    chk_val("rs_new_done",  32'(dm_done), 32'd1);
    chk_val("rs_new_rdata", dm_rdata,     32'hCAFEF00D);
    next_cycle();
    dm_req = 1'b0; mem_rvalid = 1'b0;
    sample();
    chk_val("end_stallm", 32'(StallM), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_mem_arbiter.md
# fetch_mem_arbiter

Arbiter and sequencer for the single unified memory port shared by the IF stage (instruction fetch at PCF) and the MEM stage (loads/stores). It grants one requester at a time and tracks the single outstanding transaction. It generates the fetch stall (StallF) and the memory-stage stall. It discards fetch responses invalidated by a taken branch or jump (PCSrcE), and times out hung transactions.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles waiting for mem_rvalid before abort; must be at least 2.
- CW, 7: width of timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge.
- Clr  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; PCF valid.
- if_addr  in  32  fetch address (PCF).
- PCSrcE  in  1  redirect; current fetch stream is invalid.
- if_valid  out  1  instruction returned this cycle.
- if_instr  out  32  returned instruction.
- StallF  out  1  IF must hold PCF.
- dm_req  in  1  data access request.
- dm_we  in  1  1 = store.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_wstrb  in  4  byte enables.
- dm_done  out  1  data access complete this cycle.
- dm_rdata  out  32  load data.
- StallM  out  1  MEM stage must hold.
- mem_req  out  1  port request.
- mem_we  out  1  port write enable.
- mem_addr  out  32  port address.
- mem_wdata  out  32  port write data.
- mem_wstrb  out  4  port byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response valid; this is also the store acknowledge.
- mem_rdata  in  32  response data.
- bus_err  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, IF_WAIT, DM_WAIT, IF_DROP.
- IDLE with dm_req=1:
  - Drive mem_req=1 with the dm_* fields.
  - mem_gnt=1 -> DM_WAIT.
- IDLE with dm_req=0, if_req=1, PCSrcE=0:
  - Drive mem_req=1, mem_we=0, mem_wstrb=0, mem_addr=if_addr.
  - mem_gnt=1 -> IF_WAIT.
- Priority: data always beats fetch. The older instruction completes first, which prevents deadlock.
- Request fields are muxed combinationally in IDLE. The requester holds its fields until done.
- IF_WAIT:
  - mem_rvalid=1 with PCSrcE=0 -> if_valid=1, if_instr=mem_rdata, go to IDLE.
  - mem_rvalid=1 with PCSrcE=1 -> discard the response, go to IDLE.
  - mem_rvalid=0 with PCSrcE=1 -> IF_DROP.
- IF_DROP: mem_rvalid=1 -> discard the response (if_valid stays 0), go to IDLE.
- DM_WAIT: mem_rvalid=1 -> dm_done=1, dm_rdata=mem_rdata (don't-care for stores), go to IDLE.
- StallF = if_req & ~if_valid.
- StallM = dm_req & ~dm_done.
- Timeout:
  - The counter clears on every state entry and increments each cycle in IF_WAIT, DM_WAIT or IF_DROP.
  - On reaching TIMEOUT with no mem_rvalid: pulse bus_err for 1 cycle, go to IDLE, assert no if_valid/dm_done.
  - Requesters see their stall persist and re-request.
- mem_rvalid in IDLE is ignored. It is a protocol error; no state change.
- Reset (Clr=0, any time including mid-transaction):
  - State returns to IDLE and the counter clears.
  - Registered outputs go to 0. Combinational outputs evaluate to 0, given IDLE with no requests.
  - A response arriving after reset release is ignored.

## Timing
- Mux, grant decisions and response pass-through are all combinational. No added latency.
- Best-case fetch: request and gnt in cycle N, rvalid in N+1, if_valid in N+1. Throughput is 1 fetch per 2 cycles (single outstanding).
- A data request arriving while a fetch is in IF_WAIT waits for that fetch to return. It is granted in the cycle after return.
- PCSrcE and mem_rvalid in the same IF_WAIT cycle: the data is discarded and IDLE follows. The new fetch may be granted the next cycle.
- bus_err fires exactly TIMEOUT cycles after the grant cycle.

## Structure
- Shared package riscv_pkg holds:
  - State encoding constants ST_IDLE, ST_IF_WAIT, ST_DM_WAIT, ST_IF_DROP (2-bit).
  - Default TIMEOUT.
- One sub-module, wait_timer: clear/enable counter with terminal-count flag, parameterized CW/TIMEOUT. Everything else lives in fetch_mem_arbiter.

## Test plan
- Fetch only, gnt=1, rvalid 1 cycle later, rdata=0x00500093:
  - if_valid pulses every 2nd cycle with if_instr=0x00500093.
  - StallF is low only on if_valid cycles.
- dm_req and if_req both 1 in IDLE, store to 0x100 with wdata 0xDEADBEEF and wstrb 0xF:
  - mem_we=1, mem_addr=0x100 granted first.
  - dm_done when rvalid arrives.
  - Fetch granted the next cycle.
- Fetch granted, PCSrcE=1 at wait cycle 1, rvalid at wait cycle 3 with 0x12345678:
  - State goes to IF_DROP; no if_valid.
  - IDLE the cycle after rvalid.
- PCSrcE and rvalid in the same IF_WAIT cycle: if_valid stays 0; a new fetch at the redirected address is granted the next cycle.
- TIMEOUT=8, fetch granted, rvalid never asserts: bus_err pulses 8 cycles after grant, then a new request is issued.
- Clr low during DM_WAIT:
  - mem_req, dm_done and bus_err are 0 during reset.
  - A stale rvalid after release is ignored.
  - The next dm_req is granted normally.
